// File: rtl/conv_pipe_unit.sv
// rtl/conv_pipe_unit.sv - pipelined TAPS-wide multiply / adder-tree / channel accumulator
// Define CONV_SAT_EN for saturating accumulation with sticky out_ovf; otherwise wrap-around.
module conv_pipe_unit #(
  parameter int DATA_W    = 16,
  parameter int TAPS      = 9,
  parameter int ACC_EXTRA = 4,
  localparam int SUM_W    = 2*DATA_W + $clog2(TAPS),
  localparam int OUT_W    = SUM_W + ACC_EXTRA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAPS*DATA_W-1:0] in_data,
  input  logic [TAPS*DATA_W-1:0] in_weight,
  input  logic                   in_signed,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_ovf
);
  localparam int PW = 2*DATA_W;
  localparam int GW = SUM_W - PW;

  logic                       advance;
  logic                       mode_q;
  logic                       s0_valid, s0_signed, s0_first, s0_last;
  logic [TAPS*DATA_W-1:0]     s0_data, s0_weight;
  logic                       s1_valid, s1_signed, s1_first, s1_last;
  logic [TAPS-1:0][PW-1:0]    s1_prod, prod_c;
  logic                       s2_valid, s2_signed, s2_first, s2_last;
  logic [SUM_W-1:0]           s2_sum, sum_c;
  logic [OUT_W-1:0]           acc_q, acc_next, acc_base, sum_ext;
  logic                       sat_next;
`ifdef CONV_SAT_EN
  logic                       sat_q;
  logic [OUT_W:0]             wide;
`endif

  // One global stall: every stage moves only when the output slot can take a result.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operands extended to product width, so the truncated product is exact in either mode.
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (s0_signed)
        prod_c[i] = {{DATA_W{s0_data[i*DATA_W+DATA_W-1]}}, s0_data[i*DATA_W +: DATA_W]} *
                    {{DATA_W{s0_weight[i*DATA_W+DATA_W-1]}}, s0_weight[i*DATA_W +: DATA_W]};
      else
        prod_c[i] = {{DATA_W{1'b0}}, s0_data[i*DATA_W +: DATA_W]} *
                    {{DATA_W{1'b0}}, s0_weight[i*DATA_W +: DATA_W]};
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < TAPS; i++)
      sum_c = sum_c + (s1_signed ? {{GW{s1_prod[i][PW-1]}}, s1_prod[i]}
                                 : {{GW{1'b0}}, s1_prod[i]});
  end

  always_comb begin
    sum_ext  = s2_signed ? {{ACC_EXTRA{s2_sum[SUM_W-1]}}, s2_sum} : {{ACC_EXTRA{1'b0}}, s2_sum};
    acc_base = s2_first ? '0 : acc_q;
    acc_next = acc_base + sum_ext;
    sat_next = 1'b0;
`ifdef CONV_SAT_EN
    wide = s2_signed ? ({acc_base[OUT_W-1], acc_base} + {sum_ext[OUT_W-1], sum_ext})
                     : ({1'b0, acc_base} + {1'b0, sum_ext});
    // Once a group has clamped, the accumulator stays pinned at the clamp value.
    sat_next = !s2_first && sat_q;
    if (sat_next) begin
      acc_next = acc_q;
    end else if (s2_signed && (wide[OUT_W] != wide[OUT_W-1])) begin
      sat_next = 1'b1;
      acc_next = wide[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else if (!s2_signed && wide[OUT_W]) begin
      sat_next = 1'b1;
      acc_next = '1;
    end else begin
      acc_next = wide[OUT_W-1:0];
    end
`endif
  end

  // S0 registers the accepted beat, isolating the multipliers from the feeder's timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      s0_valid  <= 1'b0;
      s0_signed <= 1'b0;
      s0_first  <= 1'b0;
      s0_last   <= 1'b0;
      s0_data   <= '0;
      s0_weight <= '0;
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_prod   <= '0;
      s2_valid  <= 1'b0;
      s2_signed <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_sum    <= '0;
      acc_q     <= '0;
`ifdef CONV_SAT_EN
      sat_q     <= 1'b0;
`endif
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      if (in_valid && in_first)
        mode_q <= in_signed;
      s0_valid  <= in_valid;
      s0_signed <= in_first ? in_signed : mode_q;
      s0_first  <= in_valid && in_first;
      s0_last   <= in_valid && in_last;
      s0_data   <= in_data;
      s0_weight <= in_weight;

      s1_valid  <= s0_valid;
      s1_signed <= s0_signed;
      s1_first  <= s0_first;
      s1_last   <= s0_last;
      s1_prod   <= prod_c;

      s2_valid  <= s1_valid;
      s2_signed <= s1_signed;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      s2_sum    <= sum_c;

      if (s2_valid) begin
        acc_q <= acc_next;
`ifdef CONV_SAT_EN
        sat_q <= sat_next;
`endif
        if (s2_last) begin
          out_data <= acc_next;
          out_ovf  <= sat_next;
        end
      end
      out_valid <= s2_valid && s2_last;
    end
  end

endmodule

// File: tb/tb_conv_pipe_unit.sv
// tb/tb_conv_pipe_unit.sv - scoreboard bench for conv_pipe_unit with a behavioural reference model
// Follows CONV_SAT_EN the same way as the design build.
module tb_conv_pipe_unit;
  localparam int DW    = 16;
  localparam int TAPS  = 9;
  localparam int OUT_W = 2*DW + $clog2(TAPS) + 4;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             ovf;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [TAPS*DW-1:0]   in_data = '0;
  logic [TAPS*DW-1:0]   in_weight = '0;
  logic                 in_signed = 1'b0;
  logic                 in_first = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [OUT_W-1:0]     out_data;
  logic                 out_ovf;

  int                   pass_cnt = 0;
  int                   total_cnt = 0;
  int                   ready_mode = 0;
  exp_t                 exp_q[$];
  logic [OUT_W-1:0]     m_acc = '0;
  logic                 m_mode = 1'b0;
  logic                 m_sat = 1'b0;
  logic                 prev_stall = 1'b0;
  logic [OUT_W-1:0]     prev_data = '0;
  logic                 stall_done = 1'b0;

  conv_pipe_unit #(.DATA_W(DW), .TAPS(TAPS), .ACC_EXTRA(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight),
    .in_signed(in_signed), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom % 2) == 1;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: exact integer sums per beat, then wrap or clamp the running group total.
  task automatic model_beat(input logic [TAPS*DW-1:0] d, input logic [TAPS*DW-1:0] w,
                            input logic sgn, input logic first, input logic last);
    logic             md;
    longint           s;
    logic [DW-1:0]    a, b;
    logic [OUT_W-1:0] base;
    exp_t             e;
`ifdef CONV_SAT_EN
    longint           bv, t, lo, hi;
`endif
    md = first ? sgn : m_mode;
    if (first) m_mode = sgn;
    s = 0;
    for (int i = 0; i < TAPS; i++) begin
      a = d[i*DW +: DW];
      b = w[i*DW +: DW];
      if (md) s += longint'($signed(a)) * longint'($signed(b));
      else    s += longint'(a) * longint'(b);
    end
    base = first ? '0 : m_acc;
    if (first) m_sat = 1'b0;
`ifdef CONV_SAT_EN
    if (!m_sat) begin
      bv = md ? longint'($signed(base)) : longint'(base);
      t  = bv + s;
      hi = md ? (longint'(1) << (OUT_W-1)) - 1 : (longint'(1) << OUT_W) - 1;
      lo = md ? -(longint'(1) << (OUT_W-1)) : 0;
      if (t > hi) begin t = hi; m_sat = 1'b1; end
      else if (t < lo) begin t = lo; m_sat = 1'b1; end
      m_acc = t[OUT_W-1:0];
    end
`else
    m_acc = base + s[OUT_W-1:0];
`endif
    if (last) begin
      e.data = m_acc;
      e.ovf  = m_sat;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [TAPS*DW-1:0] d, input logic [TAPS*DW-1:0] w,
                           input logic sgn, input logic first, input logic last);
    bit ok = 0;
    in_data = d; in_weight = w; in_signed = sgn; in_first = first; in_last = last;
    in_valid = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        model_beat(d, w, sgn, first, last);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [TAPS*DW-1:0] fill(input logic [DW-1:0] x);
    return {TAPS{x}};
  endfunction

  function automatic logic [TAPS*DW-1:0] rnd_vec();
    logic [TAPS*DW-1:0] v;
    int k = $urandom % 4;
    v = '0;
    for (int i = 0; i < TAPS; i++) begin
      case (k)
        0:       v[i*DW +: DW] = '1;
        1:       v[i*DW +: DW] = 16'h8000;
        default: v[i*DW +: DW] = DW'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic drain();
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_ready_mode(input int m);
    @(negedge clk);
    ready_mode = m;
    @(posedge clk); #1;
  endtask

  task automatic random_phase(input int n_beats);
    logic f, l;
    for (int n = 0; n < n_beats; n++) begin
      f = (n == 0) || ($urandom % 4 == 0);
      l = ($urandom % 3 == 0);
      send_beat(rnd_vec(), rnd_vec(), ($urandom % 2) == 1, f, l);
      if ($urandom % 4 == 0)
        repeat ($urandom_range(2, 1)) begin @(posedge clk); #1; end
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks held outputs under stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
        chk("stall_hold_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(out_data), 64'd0 - 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Single-beat ones, with latency measured from the accepting edge.
    send_beat(fill(16'h0001), fill(16'h0001), 1'b0, 1'b1, 1'b1);
    lat = -1; seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; lat = k; end
      else @(posedge clk);
    end
    chk("latency", 64'(lat), 64'd3);
    @(posedge clk); #1;
    drain();

    send_beat(fill(16'hFFFF), fill(16'h0002), 1'b1, 1'b1, 1'b1);
    send_beat(fill(16'hFFFF), fill(16'h0002), 1'b0, 1'b1, 1'b1);
    send_beat(fill(16'hFFFF), fill(16'hFFFF), 1'b0, 1'b1, 1'b1);
    // in_signed on non-first beats must be ignored.
    send_beat(fill(16'h0001), fill(16'h0001), 1'b0, 1'b1, 1'b0);
    send_beat(fill(16'h0001), fill(16'h0001), 1'b1, 1'b0, 1'b0);
    send_beat(fill(16'h0001), fill(16'h0001), 1'b1, 1'b0, 1'b1);
    drain();

    for (int n = 0; n < 32; n++)
      send_beat(fill(16'hFFFF), fill(16'hFFFF), 1'b0, n == 0, n == 31);
    for (int n = 0; n < 64; n++)
      send_beat(fill(16'h8000), fill(16'h8000), 1'b1, n == 0, n == 63);
    send_beat(fill(16'h0001), fill(16'h0001), 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back single-beat groups into a blocked output.
    set_ready_mode(2);
    stall_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 6; n++)
          send_beat(rnd_vec(), rnd_vec(), ($urandom % 2) == 1, 1'b1, 1'b1);
        stall_done = 1'b1;
      end
    join_none
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    ready_mode = 0;
    for (int k = 0; k < 400 && !stall_done; k++) @(posedge clk);
    chk("stall_sender_done", 64'(stall_done), 64'd1);
    #1;
    drain();

    // Reset in the middle of a group.
    send_beat(fill(16'h0003), fill(16'h0005), 1'b1, 1'b1, 1'b0);
    send_beat(fill(16'h0003), fill(16'h0005), 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    m_acc = '0; m_mode = 1'b0; m_sat = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send_beat(fill(16'h0001), fill(16'h0001), 1'b0, 1'b1, 1'b1);
    send_beat(fill(16'h0001), fill(16'h0001), 1'b0, 1'b0, 1'b1);
    drain();

    set_ready_mode(1);
    random_phase(200);
    set_ready_mode(0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
